// File: rtl/ps2_cmd_ctrl.sv
// Host-to-device PS/2 command sequencer: inhibits the bus, sends a command
// (and optional argument) frame, then waits for line ack and the device reply.
module ps2_cmd_ctrl #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int RETRY_MAX      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_has_arg,
  input  logic [7:0] cmd_arg,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] rx_byte,
  input  logic       rx_strobe,
  output logic       rx_enable,
  output logic       busy,
  output logic       done,
  output logic       error
);

  // state   | meaning
  // IDLE    | waiting for a command, receiver owns the bus
  // INHIBIT | holding ps2_clk low for INHIBIT_CYCLES
  // RTS     | clock released, start bit driven
  // TX      | shifting data, parity and stop on device clock falls
  // LACK    | waiting for the device line-ack on the next fall
  // RESP    | receiver enabled, waiting for 0xFA / 0xFE
  // DONE    | one-cycle done pulse
  // ERR     | one-cycle error pulse, lines released

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(RETRY_MAX + 2);
  localparam logic [IW-1:0] INH_LOAD = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
  localparam logic [7:0] RESP_ACK    = 8'hFA;
  localparam logic [7:0] RESP_RESEND = 8'hFE;

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_TX, S_LACK, S_RESP, S_DONE, S_ERR
  } state_t;

  state_t        state;
  logic [2:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_fall;
  logic          data_s;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [3:0]    bit_cnt;
  logic [RW-1:0] retry_cnt;
  logic [7:0]    cur_byte;
  logic [7:0]    arg_byte;
  logic          has_arg;
  logic          phase_arg;
  logic          tmo_hit;
  logic          fail_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
    end
  end

  assign clk_fall = clk_sync[2] & ~clk_sync[1];
  assign data_s   = data_sync[1];
  assign tmo_hit  = (tmo_cnt == '0);

  // A fall or rx_strobe in the same cycle as the timeout takes priority.
  always_comb begin
    fail_now = 1'b0;
    case (state)
      S_RTS:   fail_now = tmo_hit;
      S_TX:    fail_now = !clk_fall && tmo_hit;
      S_LACK:  fail_now = clk_fall ? data_s : tmo_hit;
      S_RESP:  fail_now = rx_strobe ? (rx_byte == RESP_RESEND) : tmo_hit;
      default: fail_now = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b1;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      rx_enable   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      inh_cnt     <= '0;
      tmo_cnt     <= '0;
      bit_cnt     <= '0;
      retry_cnt   <= '0;
      cur_byte    <= '0;
      arg_byte    <= '0;
      has_arg     <= 1'b0;
      phase_arg   <= 1'b0;
    end else if (fail_now) begin
      ps2_data_oe <= 1'b0;
      if (retry_cnt < RETRY_LIM) begin
        retry_cnt  <= retry_cnt + 1'b1;
        ps2_clk_oe <= 1'b1;
        rx_enable  <= 1'b0;
        inh_cnt    <= INH_LOAD;
        state      <= S_INHIBIT;
      end else begin
        ps2_clk_oe <= 1'b0;
        rx_enable  <= 1'b1;
        error      <= 1'b1;
        state      <= S_ERR;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cur_byte   <= cmd_byte;
            arg_byte   <= cmd_arg;
            has_arg    <= cmd_has_arg;
            phase_arg  <= 1'b0;
            retry_cnt  <= '0;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            ps2_clk_oe <= 1'b1;
            rx_enable  <= 1'b0;
            inh_cnt    <= INH_LOAD;
            state      <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (inh_cnt == '0) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            tmo_cnt     <= TMO_LOAD;
            state       <= S_RTS;
          end else begin
            inh_cnt <= inh_cnt - 1'b1;
          end
        end
        S_RTS: begin
          bit_cnt <= '0;
          tmo_cnt <= TMO_LOAD;
          state   <= S_TX;
        end
        S_TX: begin
          if (clk_fall) begin
            tmo_cnt <= TMO_LOAD;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt < 4'd8) begin
              ps2_data_oe <= ~cur_byte[bit_cnt[2:0]];
            end else if (bit_cnt == 4'd8) begin
              ps2_data_oe <= ~(~^cur_byte);
            end else begin
              ps2_data_oe <= 1'b0;
              state       <= S_LACK;
            end
          end else if (!tmo_hit) begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        S_LACK: begin
          if (clk_fall) begin
            tmo_cnt   <= TMO_LOAD;
            rx_enable <= 1'b1;
            state     <= S_RESP;
          end else if (!tmo_hit) begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (clk_fall) begin
            tmo_cnt <= TMO_LOAD;
          end else if (!tmo_hit) begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
          if (rx_strobe && rx_byte == RESP_ACK) begin
            if (!phase_arg && has_arg) begin
              cur_byte   <= arg_byte;
              phase_arg  <= 1'b1;
              retry_cnt  <= '0;
              ps2_clk_oe <= 1'b1;
              rx_enable  <= 1'b0;
              inh_cnt    <= INH_LOAD;
              state      <= S_INHIBIT;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        S_ERR: begin
          error     <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Directed bench for ps2_cmd_ctrl with a simple PS/2 device model on the bus.
module tb_ps2_cmd_ctrl;
  localparam int INH  = 20;
  localparam int TMO  = 300;
  localparam int RMAX = 2;
  localparam int HALF = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_byte = '0;
  logic       cmd_has_arg = 1'b0;
  logic [7:0] cmd_arg = '0;
  logic       cmd_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic [7:0] rx_byte = '0;
  logic       rx_strobe = 1'b0;
  logic       rx_enable;
  logic       busy;
  logic       done;
  logic       error;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int error_cnt = 0;

  ps2_cmd_ctrl #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .RETRY_MAX(RMAX)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .cmd_has_arg(cmd_has_arg), .cmd_arg(cmd_arg), .cmd_ready(cmd_ready),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .rx_byte(rx_byte), .rx_strobe(rx_strobe),
    .rx_enable(rx_enable), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Open-drain bus: either side pulling low wins.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  always @(negedge clk) begin
    if (done)  done_cnt++;
    if (error) error_cnt++;
  end

  task automatic issue(input logic [7:0] b, input logic ha, input logic [7:0] a,
                       output int inh_len, output bit ok);
    int n;
    n = 0;
    inh_len = 0;
    @(negedge clk);
    cmd_byte = b; cmd_has_arg = ha; cmd_arg = a; cmd_valid = 1'b1;
    @(negedge clk);
    while (!busy && n < 50) begin @(negedge clk); n++; end
    cmd_valid = 1'b0;
    ok = busy;
    if (ok) begin
      while (ps2_clk_oe && inh_len < 10 * INH) begin inh_len++; @(negedge clk); end
    end
  endtask

  // Device side of one frame: returns start, 8 data, parity, stop as bits[0..10].
  task automatic dev_frame(input bit ack, input int stop_after, output logic [10:0] bits,
                           output bit ok, output bit rx_off);
    int n;
    n = 0;
    bits = '0;
    rx_off = 1'b1;
    while (!(ps2_data_oe && !ps2_clk_oe) && n < 4000) begin @(negedge clk); n++; end
    ok = (n < 4000);
    if (ok) begin
      repeat (8) @(negedge clk);
      bits[0] = ps2_data_in;
      for (int i = 1; i <= 10; i++) begin
        if (i > stop_after) break;
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        if (rx_enable) rx_off = 1'b0;
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge clk);
        bits[i] = ps2_data_in;
      end
      if (stop_after >= 10) begin
        dev_data_low = ack;
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_data_low = 1'b0;
      end
    end
  endtask

  task automatic dev_resp(input logic [7:0] b);
    repeat (10) @(negedge clk);
    rx_byte = b;
    rx_strobe = 1'b1;
    @(negedge clk);
    rx_strobe = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({cmd_ready, ps2_clk_oe, ps2_data_oe, rx_enable, busy, done, error} !== 7'b1001000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b",
               {cmd_ready, ps2_clk_oe, ps2_data_oe, rx_enable, busy, done, error}, 7'b1001000);
    end
  endtask

  task automatic test_basic_ff;
    int len; bit ok, rx_off; logic [10:0] bits; int d0;
    d0 = done_cnt;
    issue(8'hFF, 1'b0, 8'h00, len, ok);
    checks++;
    if (!ok || len !== INH) begin errors++; $display("FAIL ff_inhibit_len: got %0d ok=%0d expected %0d", len, ok, INH); end
    checks++;
    if (ps2_data_oe !== 1'b1) begin errors++; $display("FAIL ff_start_bit: got data_oe=%b expected 1", ps2_data_oe); end
    dev_frame(1'b1, 10, bits, ok, rx_off);
    checks++;
    if (!ok || bits !== 11'h7FE) begin errors++; $display("FAIL ff_frame: got %h ok=%0d expected %h", bits, ok, 11'h7FE); end
    checks++;
    if (rx_off !== 1'b1) begin errors++; $display("FAIL ff_rx_hold: got rx_enable seen high during tx, expected low"); end
    checks++;
    if (rx_enable !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL ff_resp_state: got rx_enable=%b busy=%b expected 1 1", rx_enable, busy); end
    dev_resp(8'hFA);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL ff_done_pulse: got %b expected 1", done); end
    @(negedge clk);
    checks++;
    if ({done, busy, cmd_ready} !== 3'b001) begin errors++; $display("FAIL ff_after_done: got %b expected 001", {done, busy, cmd_ready}); end
    checks++;
    if (done_cnt !== d0 + 1) begin errors++; $display("FAIL ff_done_count: got %0d expected %0d", done_cnt, d0 + 1); end
  endtask

  task automatic test_arg_ed;
    int len; bit ok, rx_off; logic [10:0] bits; int d0;
    d0 = done_cnt;
    issue(8'hED, 1'b1, 8'h07, len, ok);
    dev_frame(1'b1, 10, bits, ok, rx_off);
    checks++;
    if (!ok || bits !== {1'b1, 1'b1, 8'hED, 1'b0}) begin errors++; $display("FAIL ed_frame: got %h expected %h", bits, {1'b1, 1'b1, 8'hED, 1'b0}); end
    dev_resp(8'hFA);
    dev_frame(1'b1, 10, bits, ok, rx_off);
    checks++;
    if (!ok || bits !== {1'b1, 1'b0, 8'h07, 1'b0}) begin errors++; $display("FAIL ed_arg_frame: got %h expected %h", bits, {1'b1, 1'b0, 8'h07, 1'b0}); end
    checks++;
    if (done_cnt !== d0) begin errors++; $display("FAIL ed_early_done: got %0d expected %0d", done_cnt, d0); end
    dev_resp(8'hFA);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL ed_done_pulse: got %b expected 1", done); end
    @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 1 || busy !== 1'b0) begin errors++; $display("FAIL ed_done_count: got %0d busy=%b expected %0d busy=0", done_cnt, busy, d0 + 1); end
  endtask

  task automatic test_resend_f3;
    int len; bit ok, rx_off; logic [10:0] bits; int d0, e0;
    d0 = done_cnt; e0 = error_cnt;
    issue(8'hF3, 1'b0, 8'h00, len, ok);
    dev_frame(1'b1, 10, bits, ok, rx_off);
    checks++;
    if (!ok || bits !== {1'b1, 1'b1, 8'hF3, 1'b0}) begin errors++; $display("FAIL f3_frame1: got %h expected %h", bits, {1'b1, 1'b1, 8'hF3, 1'b0}); end
    dev_resp(8'hFE);
    dev_frame(1'b1, 10, bits, ok, rx_off);
    checks++;
    if (!ok || bits !== {1'b1, 1'b1, 8'hF3, 1'b0}) begin errors++; $display("FAIL f3_frame2: got %h expected %h", bits, {1'b1, 1'b1, 8'hF3, 1'b0}); end
    dev_resp(8'hFA);
    @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 1 || error_cnt !== e0) begin
      errors++; $display("FAIL f3_result: got done=%0d error=%0d expected %0d %0d", done_cnt, error_cnt, d0 + 1, e0);
    end
  endtask

  task automatic test_ignore_aa;
    int len; bit ok, rx_off; logic [10:0] bits; int d0;
    d0 = done_cnt;
    issue(8'hFF, 1'b0, 8'h00, len, ok);
    dev_frame(1'b1, 10, bits, ok, rx_off);
    dev_resp(8'hAA);
    repeat (3) @(negedge clk);
    checks++;
    if ({done, busy, rx_enable} !== 3'b011 || done_cnt !== d0) begin
      errors++; $display("FAIL aa_ignored: got %b cnt=%0d expected 011 cnt=%0d", {done, busy, rx_enable}, done_cnt, d0);
    end
    dev_resp(8'hFA);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL aa_then_done: got %b expected 1", done); end
    @(negedge clk);
  endtask

  task automatic test_no_lack;
    int len; bit ok, rx_off; logic [10:0] bits; int e0, d0;
    e0 = error_cnt; d0 = done_cnt;
    issue(8'hF4, 1'b0, 8'h00, len, ok);
    for (int a = 0; a < 3; a++) begin
      dev_frame(1'b0, 10, bits, ok, rx_off);
      checks++;
      if (!ok || bits !== {1'b1, 1'b0, 8'hF4, 1'b0}) begin errors++; $display("FAIL nolack_frame%0d: got %h expected %h", a, bits, {1'b1, 1'b0, 8'hF4, 1'b0}); end
      if (a == 1) begin
        checks++;
        if (error_cnt !== e0) begin errors++; $display("FAIL nolack_early_error: got %0d expected %0d", error_cnt, e0); end
      end
    end
    checks++;
    if (error_cnt !== e0 + 1 || done_cnt !== d0) begin errors++; $display("FAIL nolack_error: got err=%0d done=%0d expected %0d %0d", error_cnt, done_cnt, e0 + 1, d0); end
    repeat (100) @(negedge clk);
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, cmd_ready, rx_enable, busy} !== 5'b00110) begin
      errors++; $display("FAIL nolack_released: got %b expected 00110", {ps2_clk_oe, ps2_data_oe, cmd_ready, rx_enable, busy});
    end
  endtask

  task automatic test_resp_timeout;
    int len, n; bit ok, rx_off; logic [10:0] bits; int e0;
    e0 = error_cnt;
    issue(8'hF4, 1'b0, 8'h00, len, ok);
    for (int a = 0; a < 3; a++) begin
      dev_frame(1'b1, 10, bits, ok, rx_off);
      checks++;
      if (!ok) begin errors++; $display("FAIL tmo_attempt%0d: got no request expected request", a); end
    end
    repeat (250) @(negedge clk);
    checks++;
    if (error_cnt !== e0 || busy !== 1'b1) begin errors++; $display("FAIL tmo_too_early: got err=%0d busy=%b expected %0d 1", error_cnt, busy, e0); end
    n = 0;
    while (error_cnt == e0 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (error_cnt !== e0 + 1) begin errors++; $display("FAIL tmo_error: got %0d expected %0d", error_cnt, e0 + 1); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_tx;
    int len; bit ok, rx_off; logic [10:0] bits; int d0;
    issue(8'hEE, 1'b0, 8'h00, len, ok);
    dev_frame(1'b1, 5, bits, ok, rx_off);
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, rx_enable} !== 3'b010) begin errors++; $display("FAIL midtx_before: got %b expected 010", {ps2_clk_oe, ps2_data_oe, rx_enable}); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, rx_enable, busy, cmd_ready} !== 5'b00101) begin
      errors++; $display("FAIL midtx_async_reset: got %b expected 00101", {ps2_clk_oe, ps2_data_oe, rx_enable, busy, cmd_ready});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    issue(8'hFF, 1'b0, 8'h00, len, ok);
    checks++;
    if (!ok || len !== INH) begin errors++; $display("FAIL midtx_restart_inhibit: got %0d expected %0d", len, INH); end
    dev_frame(1'b1, 10, bits, ok, rx_off);
    checks++;
    if (!ok || bits !== 11'h7FE) begin errors++; $display("FAIL midtx_restart_frame: got %h expected %h", bits, 11'h7FE); end
    dev_resp(8'hFA);
    @(negedge clk);
    checks++;
    if (done_cnt !== d0 + 1) begin errors++; $display("FAIL midtx_restart_done: got %0d expected %0d", done_cnt, d0 + 1); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    test_basic_ff;
    test_arg_ed;
    test_resend_f3;
    test_ignore_aa;
    test_no_lack;
    test_resp_timeout;
    test_reset_mid_tx;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
